// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operand width,
// muldiv opcodes and the iteration FSM state encoding.
package mips_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] MD_OP_NONE  = 3'd0;
    localparam logic [2:0] MD_OP_MULT  = 3'd1;
    localparam logic [2:0] MD_OP_MULTU = 3'd2;
    localparam logic [2:0] MD_OP_DIV   = 3'd3;
    localparam logic [2:0] MD_OP_DIVU  = 3'd4;
    localparam logic [2:0] MD_OP_MTHI  = 3'd5;
    localparam logic [2:0] MD_OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Iterative datapath: one shift-add multiply step or one restoring
// shift-subtract divide step per cycle on unsigned magnitudes.
module md_iter_core
    import mips_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_is_div,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_next;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? i_a : i_b)};
            r_opnd   <= i_is_div ? i_b : i_a;
            r_is_div <= i_is_div;
        end else if (i_step) begin
            r_acc    <= r_is_div ? w_div_next : w_mul_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO,
// MFHI/MFLO read-out and a stall to hazard logic while a result is pending.
module ex_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_rs_val,
    input  logic [WIDTH-1:0] i_rt_val,
    input  logic             i_mf_req,
    input  logic             i_mf_hi,
    input  logic             i_kill,
    output logic             o_busy,
    output logic             o_stall,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_mf_data
);

    localparam int CW = $clog2(ITER + 1);

    md_state_t          r_state;
    md_state_t          w_state_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_rs_raw;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_md;
    logic               w_op_div;
    logic               w_op_signed;
    logic               w_accept;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic               w_load;
    logic               w_step;
    logic               w_fix_we;
    logic               w_last_step;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_is_md     = (i_op == MD_OP_MULT) || (i_op == MD_OP_MULTU) ||
                         (i_op == MD_OP_DIV)  || (i_op == MD_OP_DIVU);
    assign w_op_div    = (i_op == MD_OP_DIV)  || (i_op == MD_OP_DIVU);
    assign w_op_signed = (i_op == MD_OP_MULT) || (i_op == MD_OP_DIV);
    assign w_accept    = i_start & ~i_kill & (r_state == MD_IDLE);

    assign w_rs_neg = w_op_signed & i_rs_val[WIDTH-1];
    assign w_rt_neg = w_op_signed & i_rt_val[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -i_rs_val : i_rs_val;
    assign w_rt_mag = w_rt_neg ? -i_rt_val : i_rt_val;

    assign w_last_step = (r_cnt == CW'(ITER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MD_IDLE: if (w_accept && w_is_md) w_state_next = MD_RUN;
            MD_RUN:  if (w_last_step)         w_state_next = MD_FIX;
            MD_FIX:                           w_state_next = MD_IDLE;
            default:                          w_state_next = MD_IDLE;
        endcase
        if (i_kill) w_state_next = MD_IDLE;
    end

    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_fix_we = 1'b0;
        case (r_state)
            MD_IDLE: w_load   = w_accept & w_is_md;
            MD_RUN:  w_step   = ~i_kill;
            MD_FIX:  w_fix_we = ~i_kill;
            default: ;
        endcase
    end

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (w_op_div),
        .i_a      (w_rs_mag),
        .i_b      (w_rt_mag),
        .o_acc    (w_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_rs_raw <= '0;
        end else if (i_kill) begin
            r_cnt    <= '0;
        end else if (w_load) begin
            r_cnt    <= '0;
            r_is_div <= w_op_div;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_dz     <= w_op_div & (i_rt_val == '0);
            r_rs_raw <= i_rs_val;
        end else if (w_step) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Sign fix-up; a zero divisor bypasses the iterated result entirely.
    assign w_prod = r_neg_q ? -w_acc : w_acc;

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_res_hi = r_rs_raw;
                w_res_lo = '1;
            end else begin
                w_res_hi = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
                w_res_lo = r_neg_q ? -w_acc[WIDTH-1:0]       : w_acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix_we) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_accept && i_op == MD_OP_MTHI) begin
            r_hi <= i_rs_val;
        end else if (w_accept && i_op == MD_OP_MTLO) begin
            r_lo <= i_rs_val;
        end
    end

    assign o_busy    = (r_state != MD_IDLE);
    assign o_stall   = o_busy & (i_start | i_mf_req);
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;
    assign o_mf_data = i_mf_hi ? r_hi : r_lo;

endmodule
